// File: rtl/rr_mux_if.sv
// Handshake bundle for rr_mux: NUM_CH valid/ready/data inputs merged onto one valid/ready output.
// The slave modport is the mux side. The master modport is the producer/consumer side.
interface rr_mux_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]       in_valid_i;
  logic [NUM_CH*WIDTH-1:0] in_data_i;
  logic [NUM_CH-1:0]       in_ready_o;
  logic                    out_valid_o;
  logic [WIDTH-1:0]        out_data_o;
  logic [SEL_W-1:0]        out_sel_o;
  logic                    out_ready_i;

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_sel_o
  );

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_sel_o
  );
endinterface

// File: rtl/rr_mux.sv
// N-channel registered merge stage with round-robin arbitration and valid/ready on every port.
// Define RR_MUX_FIXED_PRIO_EN to select fixed lowest-index-wins priority (the pointer becomes constant 0).
module rr_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
) (
  input  logic    clk,
  input  logic    reset,
  rr_mux_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic                    out_valid_reg;
  logic [WIDTH-1:0]        out_data_reg;
  logic [SEL_W-1:0]        out_sel_reg;
  logic [SEL_W-1:0]        ptr_reg;
  logic [SEL_W-1:0]        ptr_next;

  logic                    accept;
  logic                    grant_valid;
  logic [SEL_W-1:0]        grant_idx;
  logic [NUM_CH-1:0]       in_ready_next;
  logic [SEL_W-1:0]        cand_idx [NUM_CH];
  logic [NUM_CH-1:0]       cand_valid;

  assign accept = !out_valid_reg || bus.out_ready_i;

  // Scan position gi maps to channel (ptr + gi) mod NUM_CH; one subtraction suffices since both terms are < NUM_CH.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_scan
      logic [SEL_W:0] sum;
      assign sum = {1'b0, ptr_reg} + (SEL_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (SEL_W+1)'(NUM_CH)) ? SEL_W'(sum - (SEL_W+1)'(NUM_CH))
                                                       : sum[SEL_W-1:0];
      assign cand_valid[gi] = bus.in_valid_i[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cand_valid[i]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx[i];
      end
    end
  end

  always_comb begin
    in_ready_next = '0;
    if (accept && grant_valid && !reset) begin
      in_ready_next[grant_idx] = 1'b1;
    end
  end

  assign ptr_next = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

`ifdef RR_MUX_FIXED_PRIO_EN
  assign ptr_reg = '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
    end else if (accept) begin
      out_valid_reg <= grant_valid;
      if (grant_valid) begin
        out_data_reg <= bus.in_data_i[grant_idx*WIDTH +: WIDTH];
        out_sel_reg  <= grant_idx;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      ptr_reg       <= '0;
    end else if (accept) begin
      out_valid_reg <= grant_valid;
      if (grant_valid) begin
        out_data_reg <= bus.in_data_i[grant_idx*WIDTH +: WIDTH];
        out_sel_reg  <= grant_idx;
        ptr_reg      <= ptr_next;
      end
    end
  end
`endif

  assign bus.in_ready_o  = in_ready_next;
  assign bus.out_valid_o = out_valid_reg;
  assign bus.out_data_o  = out_data_reg;
  assign bus.out_sel_o   = out_sel_reg;
endmodule

// File: tb/tb_rr_mux.sv
// Randomised bench for rr_mux against a distance-based arbitration model, plus literal directed checks.
module tb_rr_mux;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  rr_mux_if #(.WIDTH(8), .NUM_CH(4)) bus4 ();
  rr_mux_if #(.WIDTH(8), .NUM_CH(3)) bus3 ();

  rr_mux #(.WIDTH(8), .NUM_CH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  rr_mux #(.WIDTH(8), .NUM_CH(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Winner is the valid channel at the smallest forward distance from the pointer.
  function automatic int winner(input logic [3:0] v, input int p);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = 4;
    for (int k = 0; k < 4; k++) begin
      if (v[k]) begin
        d = (k - p + 4) % 4;
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  logic       m_valid;
  logic [7:0] m_data;
  int         m_sel;
  int         m_ptr;

  always @(posedge clk or posedge reset) begin : model
    int w;
    if (reset) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_sel   = 0;
      m_ptr   = 0;
    end else if (!m_valid || bus4.out_ready_i) begin
      w = winner(bus4.in_valid_i, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = bus4.in_data_i[w*8 +: 8];
        m_sel   = w;
`ifndef RR_MUX_FIXED_PRIO_EN
        m_ptr   = (w + 1) % 4;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int w;
    logic [3:0] e;
    e = 4'b0000;
    if (!reset && (!m_valid || bus4.out_ready_i)) begin
      w = winner(bus4.in_valid_i, m_ptr);
      if (w >= 0) e[w] = 1'b1;
    end
    check("in_ready", 32'(bus4.in_ready_o), 32'(e));
    if (reset) begin
      check("rst_valid", 32'(bus4.out_valid_o), 32'd0);
      check("rst_data",  32'(bus4.out_data_o),  32'd0);
      check("rst_sel",   32'(bus4.out_sel_o),   32'd0);
    end else begin
      check("out_valid", 32'(bus4.out_valid_o), 32'(m_valid));
      if (m_valid) begin
        check("out_data", 32'(bus4.out_data_o), 32'(m_data));
        check("out_sel",  32'(bus4.out_sel_o),  32'(m_sel));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic set_all4();
    bus4.in_valid_i = 4'b1111;
    for (int k = 0; k < 4; k++) bus4.in_data_i[k*8 +: 8] = 8'(8'h10 + k);
  endtask

  initial begin
    int exp_sel;
    reset            = 1'b1;
    bus4.in_valid_i  = '0;
    bus4.in_data_i   = '0;
    bus4.out_ready_i = 1'b0;
    bus3.in_valid_i  = '0;
    bus3.in_data_i   = '0;
    bus3.out_ready_i = 1'b0;
    repeat (2) step();
    check("lit_reset_valid", 32'(bus4.out_valid_o), 32'd0);
    check("lit_reset_ready", 32'(bus4.in_ready_o), 32'd0);
    reset = 1'b0;

    // Async reset while a word 0x33 is held
    bus4.in_valid_i = 4'b0001;
    bus4.in_data_i  = 32'h0000_0033;
    step();
    check("lit_held_valid", 32'(bus4.out_valid_o), 32'd1);
    check("lit_held_data",  32'(bus4.out_data_o),  32'h33);
    #1 reset = 1'b1;
    #1;
    check("lit_async_valid", 32'(bus4.out_valid_o), 32'd0);
    check("lit_async_data",  32'(bus4.out_data_o),  32'd0);
    check("lit_async_sel",   32'(bus4.out_sel_o),   32'd0);
    check("lit_async_ready", 32'(bus4.in_ready_o),  32'd0);
    #1 reset = 1'b0;
    bus4.in_valid_i = 4'b0000;
    step();

    // Single channel
    bus4.in_valid_i  = 4'b0100;
    bus4.in_data_i   = 32'h00AA_0000;
    bus4.out_ready_i = 1'b1;
    #1;
    check("lit_single_ready", 32'(bus4.in_ready_o), 32'b0100);
    step();
    check("lit_single_valid", 32'(bus4.out_valid_o), 32'd1);
    check("lit_single_data",  32'(bus4.out_data_o),  32'hAA);
    check("lit_single_sel",   32'(bus4.out_sel_o),   32'd2);
    bus4.in_valid_i = 4'b0000;
    step();

    // Rotation from channel 0
    pulse_reset();
    set_all4();
    for (int i = 0; i < 5; i++) begin
      step();
`ifdef RR_MUX_FIXED_PRIO_EN
      exp_sel = 0;
`else
      exp_sel = i % 4;
`endif
      check("lit_rot_sel",  32'(bus4.out_sel_o),  32'(exp_sel));
      check("lit_rot_data", 32'(bus4.out_data_o), 32'(8'h10 + exp_sel));
    end

    // Backpressure with 0x12 held (0x10 under fixed priority)
    pulse_reset();
    set_all4();
    repeat (3) step();
    bus4.out_ready_i = 1'b0;
`ifdef RR_MUX_FIXED_PRIO_EN
    exp_sel = 0;
`else
    exp_sel = 2;
`endif
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lit_bp_ready", 32'(bus4.in_ready_o), 32'd0);
      step();
      check("lit_bp_valid", 32'(bus4.out_valid_o), 32'd1);
      check("lit_bp_data",  32'(bus4.out_data_o),  32'(8'h10 + exp_sel));
    end
    bus4.out_ready_i = 1'b1;
    #1;
`ifdef RR_MUX_FIXED_PRIO_EN
    check("lit_bp_release", 32'(bus4.in_ready_o), 32'b0001);
    step();
    check("lit_bp_next", 32'(bus4.out_sel_o), 32'd0);
`else
    check("lit_bp_release", 32'(bus4.in_ready_o), 32'b1000);
    step();
    check("lit_bp_next", 32'(bus4.out_sel_o), 32'd3);
`endif

    // Channel 0 dropped: fixed priority settles on channel 1
    bus4.in_valid_i = 4'b1110;
    step();
    check("lit_drop0_a", 32'(bus4.out_sel_o), 32'd1);
    step();
`ifdef RR_MUX_FIXED_PRIO_EN
    check("lit_drop0_b", 32'(bus4.out_sel_o), 32'd1);
`else
    check("lit_drop0_b", 32'(bus4.out_sel_o), 32'd2);
`endif

    // Non-power-of-two wrap on the 3-channel instance
    pulse_reset();
    bus3.in_valid_i  = 3'b101;
    bus3.in_data_i   = 24'hA2_A1_A0;
    bus3.out_ready_i = 1'b1;
    #1;
    check("lit_n3_ready", 32'(bus3.in_ready_o), 32'b001);
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef RR_MUX_FIXED_PRIO_EN
      exp_sel = 0;
`else
      exp_sel = (i % 2) * 2;
`endif
      check("lit_n3_sel",  32'(bus3.out_sel_o),  32'(exp_sel));
      check("lit_n3_data", 32'(bus3.out_data_o), 32'(8'hA0 + exp_sel));
    end

    // Random traffic with occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      bus4.in_valid_i  = 4'($urandom_range(0, 15));
      bus4.in_data_i   = $urandom;
      bus4.out_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1'b1;
        #5 reset = 1'b0;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. Each cycle, one pending input channel is chosen by round-robin arbitration and its data and channel index are loaded into a single output register. The block generalises the team's 8-bit 2:1 combinational mux into a flow-controlled merge stage. It is used wherever several producers share one downstream consumer.

## Interface
- `WIDTH`, 8: data width in bits per channel (≥1).
- `NUM_CH`, 4: number of input channels (≥2, need not be a power of two).
- `SEL_W`: localparam, `$clog2(NUM_CH)`, width of the channel index.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid_i` input NUM_CH: bit k set means channel k presents data.
- `in_data_i` input NUM_CH*WIDTH: flattened inputs; channel k occupies `[k*WIDTH +: WIDTH]`.
- `in_ready_o` output NUM_CH: one-hot (or zero) grant; channel k transfers when `in_valid_i[k] && in_ready_o[k]`.
- `out_valid_o` output 1: the output register holds a word.
- `out_data_o` output WIDTH: registered data.
- `out_sel_o` output SEL_W: index of the channel that supplied `out_data_o`.
- `out_ready_i` input 1: the consumer accepts the word when `out_valid_o && out_ready_i`.

## Operation
- `accept = !out_valid_o || out_ready_i`. The register is empty, or it is draining this cycle.
- Arbitration is combinational. The block scans channels `ptr, ptr+1, …, NUM_CH-1, 0, …, ptr-1` and grants the first one with `in_valid_i` set.
- `in_ready_o = accept ? onehot(grant) : 0`. At most one bit is ever set. When no channel is valid, the output is 0.
- On a clock edge with `accept` and a grant:
  - load `out_data_o` and `out_sel_o` from the granted channel;
  - set `out_valid_o` to 1;
  - set `ptr` to `grant+1`, wrapping from `NUM_CH-1` to 0.
- On a clock edge with `accept` and no valid input: `out_valid_o` goes to 0. `out_data_o` and `out_sel_o` hold their values; their contents are don't-care while invalid. `ptr` is unchanged.
- When `!accept`, the output register and `ptr` hold. `in_ready_o` stays all-zero, so no input is consumed.
- `ptr` is a SEL_W-bit register and never exceeds `NUM_CH-1`. This holds for non-power-of-two `NUM_CH`.
- Simultaneous output drain and new grant in the same cycle is the normal case. The block sustains one transfer per cycle.
- A channel that deasserts `in_valid_i` before it is granted loses nothing; the block holds no per-channel state.

## Timing
- Reset values (applied asynchronously, immediately): `out_valid_o=0`, `out_data_o=0`, `out_sel_o=0`, `ptr=0`.
- While reset is asserted, `in_ready_o` is all-zero.
- Reset asserted mid-operation discards the held word. The first grant after release starts at channel 0.
- Latency: an input handshake in cycle n appears on `out_*` in cycle n+1.
- Throughput: 1 word per cycle while `out_ready_i=1`.
- Combinational paths: `in_valid_i`, `out_ready_i` → `in_ready_o`. There is no combinational path from any input to `out_*`.
- Fairness: a channel that keeps `in_valid_i` asserted is granted within `NUM_CH` accepted transfers.

## Configuration
- `RR_MUX_FIXED_PRIO_EN` undefined (default): round-robin arbitration as described above.
- `RR_MUX_FIXED_PRIO_EN` defined:
  - fixed priority; the lowest-index valid channel always wins;
  - `ptr` is removed, or tied to 0;
  - handshake and output register behaviour are otherwise identical.

## Test plan
All scenarios use WIDTH=8 and NUM_CH=4 unless stated otherwise.

1. **Asynchronous reset mid-operation.** With `out_valid_o=1` and `out_data_o=0x33`, assert `reset` between clock edges → immediately `out_valid_o=0`, `out_data_o=0x00`, `out_sel_o=0`, `in_ready_o=4'b0000`.
2. **Single channel.** Set `in_valid_i=4'b0100`, channel 2 data `0xAA`, `out_ready_i=1` → `in_ready_o=4'b0100` in the same cycle. After the next edge, `out_valid_o=1`, `out_data_o=0xAA`, `out_sel_o=2`.
3. **Round-robin rotation.** Hold all channels valid with channel k data `0x10+k` and `out_ready_i=1` → back-to-back outputs `0x10,0x11,0x12,0x13,0x10` with `out_sel_o` equal to `0,1,2,3,0`.
4. **Backpressure.** With a word `0x12` held, drop `out_ready_i` to 0 for 3 cycles → `out_data_o` stays `0x12`, `out_valid_o=1`, `in_ready_o=0000` throughout. On release, `0x12` is consumed and the next grant is channel 3.
5. **Wrap with non-power-of-two count.** With NUM_CH=3, set `in_valid_i=3'b101` continuously → `out_sel_o` sequence is `0,2,0,2`, and `ptr` wraps from 2 to 0.
6. **Fixed priority.** With `RR_MUX_FIXED_PRIO_EN` defined and all channels valid → `out_sel_o=0` every cycle. After `in_valid_i[0]` is deasserted → `out_sel_o=1` every cycle.
